sha256_msg_schedule: RTL and testbench

Streaming SHA-256 message-schedule expander. Accepts one 512-bit block as 16 serial 32-bit words, then emits the 64-word schedule W[0..63] one word per cycle under valid/ready back-pressure. It sits directly upstream of the ALU-based round datapath, supplying the W[t] operand each compression round. Expansion uses the same rotate/XOR/add primitives the ALU provides.

---
 rtl/sha256_pkg.sv | 23 ++
 rtl/sha256_small_sigma.sv | 22 ++
 rtl/sha256_msg_schedule.sv | 131 +++++++++++++
 tb/tb_sha256_msg_schedule.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message-schedule expander.
//   S0_*/S1_*   : rotate/shift amounts of the small sigma functions s0/s1
//   BLOCK_WORDS : message words per 512-bit block
//   MAX_ROUNDS  : largest schedule length supported
//   state_e     : schedule FSM states
package sha256_pkg;

  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;
  localparam int unsigned S1_R1 = 17;
  localparam int unsigned S1_R2 = 19;
  localparam int unsigned S1_SH = 10;

  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned MAX_ROUNDS  = 64;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: y = ROTR(x,R1) ^ ROTR(x,R2) ^ SHR(x,SH). Purely combinational.
//   x : input word
//   y : sigma result
module sha256_small_sigma #(
  parameter int unsigned R1 = 7,
  parameter int unsigned R2 = 18,
  parameter int unsigned SH = 3
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [31:0] rot1;
  logic [31:0] rot2;
  logic [31:0] shr;

  assign rot1 = (x >> R1) | (x << (32 - R1));
  assign rot2 = (x >> R2) | (x << (32 - R2));
  assign shr  = x >> SH;
  assign y    = rot1 ^ rot2 ^ shr;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Streaming SHA-256 message-schedule expander. Loads 16 message words, then
// emits W[0..ROUNDS-1] one per cycle under valid/ready handshaking.
//   clock, reset       : rising-edge clock, async active-high reset
//   flush              : synchronous abort of the current block
//   in_valid/in_ready/in_data   : message word input (W[0] first)
//   out_valid/out_ready/out_data: schedule word output
//   out_index          : t of the word on out_data
//   out_last           : marks W[ROUNDS-1]
//   busy               : high while emitting
//
// state | meaning
// LOAD  | accepting message words into the buffer
// EMIT  | presenting schedule words, expanding in place for t >= 16
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        busy
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] wbuf_q [BLOCK_WORDS];
  logic [31:0] wbuf_d [BLOCK_WORDS];

  logic [3:0]  t_lo, i_m2, i_m7, i_m15;
  logic [31:0] s0_out, s1_out;
  logic [31:0] w_exp, w_cur;
  logic        in_fire, out_fire, expanding;

  // The 16-entry ring holds W[t-16..t-1]; slot t&15 holds W[t-16], which is
  // overwritten by W[t] once it is handed off.
  assign t_lo  = t_q[3:0];
  assign i_m2  = t_lo + 4'd14;
  assign i_m7  = t_lo + 4'd9;
  assign i_m15 = t_lo + 4'd1;

  sha256_small_sigma #(.R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_s0 (
    .x (wbuf_q[i_m15]),
    .y (s0_out)
  );

  sha256_small_sigma #(.R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_s1 (
    .x (wbuf_q[i_m2]),
    .y (s1_out)
  );

  assign w_exp     = s1_out + wbuf_q[i_m7] + s0_out + wbuf_q[t_lo];
  assign expanding = (t_q[5:4] != 2'b00);
  assign w_cur     = expanding ? w_exp : wbuf_q[t_lo];

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_data  = (state_q == EMIT) ? w_cur : 32'd0;
  assign out_index = t_q;
  assign out_last  = (state_q == EMIT) && (t_q == LAST_T);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    wbuf_d  = wbuf_q;
    if (flush) begin
      state_d = LOAD;
      cnt_d   = 4'd0;
      t_d     = 6'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            wbuf_d[cnt_q] = in_data;
            cnt_d         = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = EMIT;
              t_d     = 6'd0;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (expanding) begin
              wbuf_d[t_lo] = w_cur;
            end
            if (t_q == LAST_T) begin
              state_d = LOAD;
              cnt_d   = 4'd0;
              t_d     = 6'd0;
            end else begin
              t_d = t_q + 6'd1;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      wbuf_q  <= '{default: 32'd0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      wbuf_q  <= wbuf_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  localparam int ROUNDS = 64;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [31:0] in_data, out_data;
  logic [5:0]  out_index;

  always #5 clock = ~clock;

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sch_t [64];
  typedef struct {logic [31:0] data; logic [5:0] idx; logic last;} exp_t;
  typedef struct {int pat; int idx; logic [31:0] exp; string name;} vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] got [64];
  int   last_hs_cyc = -100;
  bit   chk_ready_next = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void model(input blk_t m, output sch_t w);
    logic [31:0] a, b;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      a = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      b = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = b + w[t-7] + a + w[t-16];
    end
  endfunction

  // Scoreboard monitor: compares every output handshake against the queue.
  always @(negedge clock) begin
    if (!reset && chk_ready_next) begin
      chk_ready_next = 0;
      check32("in_ready_after_last", {31'd0, in_ready}, 32'd1);
    end
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got index %0d data %08h, expected none", out_index, out_data);
      end else begin
        e = sb.pop_front();
        check32($sformatf("data_w%0d", e.idx), out_data, e.data);
        check32($sformatf("index_w%0d", e.idx), {26'd0, out_index}, {26'd0, e.idx});
        check32($sformatf("last_w%0d", e.idx), {31'd0, out_last}, {31'd0, e.last});
        got[out_index] = out_data;
        if (out_last) begin
          last_hs_cyc    = cyc;
          chk_ready_next = 1;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, output int hc);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    hc = cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic load_block(input blk_t m, input bit keep_valid, output int first_cyc);
    sch_t w;
    exp_t x;
    int   hc;
    model(m, w);
    for (int t = 0; t < ROUNDS; t++) begin
      x.data = w[t];
      x.idx  = 6'(t);
      x.last = (t == ROUNDS - 1);
      sb.push_back(x);
    end
    first_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      send_word(m[i], hc);
      if (i == 0) first_cyc = hc;
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check32({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    check32({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check32({tag, "_out_data"},  out_data,           32'd0);
    check32({tag, "_out_index"}, {26'd0, out_index}, 32'd0);
    check32({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    check32({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  task automatic wait_index(input logic [5:0] idx);
    int n;
    n = 0;
    @(negedge clock);
    while (!(out_valid && out_index == idx) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!(out_valid && out_index == idx)) begin
      checks++;
      errors++;
      $display("FAIL wait_index: got index %0d expected %0d", out_index, idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t abc, ones, rb, b1, b2;
    sch_t abc_w;
    logic [31:0] cap [2][64];
    vec_t vecs [6];
    logic [31:0] hold;
    int fc, fc1, fc2, hc;

    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'd0;
      ones[i] = 32'hFFFF_FFFF;
    end
    abc[0]  = 32'h6162_6380;
    abc[15] = 32'h0000_0018;
    model(abc, abc_w);

    vecs[0] = '{0, 0,  32'h6162_6380, "abc_w0"};
    vecs[1] = '{0, 16, 32'h6162_6380, "abc_w16"};
    vecs[2] = '{0, 17, 32'h000F_0000, "abc_w17"};
    vecs[3] = '{0, 63, 32'h12B1_EDEB, "abc_w63"};
    vecs[4] = '{1, 0,  32'hFFFF_FFFF, "ones_w0"};
    vecs[5] = '{1, 16, 32'h203F_FFFC, "ones_w16"};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
    #12;
    check_reset_outs("por");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Known-answer blocks, then table compare of captured words.
    load_block(abc, 0, fc);
    check32("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check32("latency_index0", {26'd0, out_index}, 32'd0);
    wait_drain();
    for (int i = 0; i < 64; i++) cap[0][i] = got[i];
    load_block(ones, 0, fc);
    wait_drain();
    for (int i = 0; i < 64; i++) cap[1][i] = got[i];
    for (int v = 0; v < 6; v++)
      check32(vecs[v].name, cap[vecs[v].pat][vecs[v].idx], vecs[v].exp);

    // Back-pressure: hold out_ready low for 5 cycles at t=20.
    load_block(abc, 0, fc);
    wait_index(6'd19);
    @(posedge clock); #1;
    out_ready = 1'b0;
    hold = out_data;
    check32("stall_w20_value", hold, abc_w[20]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check32("stall_index_hold", {26'd0, out_index}, 32'd20);
      check32("stall_data_hold", out_data, hold);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset mid-emit at t=40.
    load_block(abc, 0, fc);
    wait_index(6'd40);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outs("async_rst");
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    load_block(abc, 0, fc);
    wait_drain();
    check32("post_rst_w16", got[16], 32'h6162_6380);

    // Flush after 9 words, coincident with an offered word.
    for (int i = 0; i < 9; i++) send_word(32'hA5A5_0000 + 32'(i), hc);
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clock); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check32("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check32("flush_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 16; i++) rb[i] = $urandom();
    load_block(rb, 0, fc);
    wait_drain();

    // Back-to-back blocks with in_valid held high.
    for (int i = 0; i < 16; i++) begin
      b1[i] = $urandom();
      b2[i] = $urandom();
    end
    load_block(b1, 1, fc1);
    load_block(b2, 0, fc2);
    check32("b2b_first_hs_after_last", 32'(fc2), 32'(last_hs_cyc + 1));
    check32("b2b_block_period", 32'(fc2 - fc1), 32'(16 + ROUNDS));
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
